// File: rtl/dual_port_ram_pkg.sv
// Shared definitions for the dual-port RAM: collision modes, sweep states and
// the byte-lane merge used by both the write path and write-first reads.
package ram_pkg;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Widest word / lane mask the merge helper handles; DATA_BITS must stay below this.
  localparam int MAX_DATA_BITS = 256;
  localparam int MAX_LANES     = 256;
  localparam int SEL_BITS      = $clog2(MAX_DATA_BITS);

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  function automatic logic [MAX_DATA_BITS-1:0] lane_merge(
    input logic [MAX_DATA_BITS-1:0] old_word,
    input logic [MAX_DATA_BITS-1:0] new_word,
    input logic [MAX_LANES-1:0]     lanes,
    input int                       byte_bits
  );
    logic [MAX_DATA_BITS-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_BITS; i++) begin
      if (lanes[SEL_BITS'(i / byte_bits)]) merged[SEL_BITS'(i)] = new_word[SEL_BITS'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_ram_if.sv
// Request/response bundle of the dual-port RAM: clear control, write port and
// registered read port.
interface dual_port_ram_if #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_BITS    = 32,
  parameter int BYTE_BITS    = 8
);
  localparam int LANES = DATA_BITS / BYTE_BITS;

  logic                    clear;
  logic                    busy;
  logic                    write;
  logic [ADDRESS_BITS-1:0] write_address;
  logic [DATA_BITS-1:0]    write_data;
  logic [LANES-1:0]        write_lanes;
  logic                    read;
  logic [ADDRESS_BITS-1:0] read_address;
  logic [DATA_BITS-1:0]    read_data;
  logic                    read_valid;

  modport master (
    output clear, write, write_address, write_data, write_lanes, read, read_address,
    input  busy, read_data, read_valid
  );

  modport slave (
    input  clear, write, write_address, write_data, write_lanes, read, read_address,
    output busy, read_data, read_valid
  );

endinterface

// File: rtl/ram_clear_sequencer.sv
// Clear sweep controller: walks every address once, writing zero, after reset
// or an accepted clear request; busy is high for the whole sweep.
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int ADDRESS_BITS = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  output logic                    busy,
  output logic                    clear_write,
  output logic [ADDRESS_BITS-1:0] clear_address
);

  localparam logic [ADDRESS_BITS-1:0] LAST_ADDRESS = '1;

  state_t                  state;
  logic [ADDRESS_BITS-1:0] counter;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEARING;
      counter <= '0;
    end else begin
      case (state)
        CLEARING: begin
          counter <= counter + 1'b1;
          if (counter == LAST_ADDRESS) state <= IDLE;
        end
        IDLE: begin
          if (clear) begin
            state   <= CLEARING;
            counter <= '0;
          end
        end
        default: state <= CLEARING;
      endcase
    end
  end

  assign busy          = (state == CLEARING);
  assign clear_write   = busy;
  assign clear_address = counter;

endmodule

// File: rtl/dual_port_ram.sv
// One-write/one-read RAM with byte lanes, registered read, selectable collision
// behaviour and a one-word-per-cycle clear sweep.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_BITS    = 32,
  parameter int BYTE_BITS    = 8,
  parameter int READ_MODE    = READ_FIRST
) (
  input logic             clock,
  input logic             reset_n,
  dual_port_ram_if.slave  bus
);

  localparam int DEPTH = 1 << ADDRESS_BITS;

  logic                    busy;
  logic                    clear_write;
  logic [ADDRESS_BITS-1:0] clear_address;

  ram_clear_sequencer #(.ADDRESS_BITS(ADDRESS_BITS)) u_sequencer (
    .clock         (clock),
    .reset_n       (reset_n),
    .clear         (bus.clear),
    .busy          (busy),
    .clear_write   (clear_write),
    .clear_address (clear_address)
  );

  // A clear request on an idle edge drops that edge's read and write.
  logic accept, user_write, user_read;
  assign accept     = !busy && !bus.clear;
  assign user_write = accept && bus.write;
  assign user_read  = accept && bus.read;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [DATA_BITS-1:0]               old_word, merged, read_word;
  logic [MAX_DATA_BITS-DATA_BITS-1:0] merge_unused;
  logic                               collision;

  assign old_word = mem[bus.write_address];
  assign {merge_unused, merged} = lane_merge(MAX_DATA_BITS'(old_word),
                                             MAX_DATA_BITS'(bus.write_data),
                                             MAX_LANES'(bus.write_lanes),
                                             BYTE_BITS);
  assign collision = user_write && (bus.write_address == bus.read_address);

  // NOTE: default assignment first so always_comb cannot infer a latch.
  always_comb begin
    read_word = mem[bus.read_address];
    if (READ_MODE == WRITE_FIRST && collision) read_word = merged;
  end

  // NOTE: the array has no reset; the sweep zeroes it so it still maps to block RAM.
  always_ff @(posedge clock) begin
    if (clear_write)     mem[clear_address]     <= '0;
    else if (user_write) mem[bus.write_address] <= merged;
  end

  logic [DATA_BITS-1:0] read_data_q;
  logic                 read_valid_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= user_read;
      if (user_read) read_data_q <= read_word;
    end
  end

  assign bus.busy       = busy;
  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: a read-first and a write-first instance share one
// stimulus stream; expected read words are queued per instance and popped on read_valid.
module tb_dual_port_ram;

  localparam int AB    = 4;
  localparam int DB    = 32;
  localparam int DEPTH = 1 << AB;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dual_port_ram_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .BYTE_BITS(8)) bus_rf ();
  dual_port_ram_if #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .BYTE_BITS(8)) bus_wf ();

  assign bus_wf.clear         = bus_rf.clear;
  assign bus_wf.write         = bus_rf.write;
  assign bus_wf.write_address = bus_rf.write_address;
  assign bus_wf.write_data    = bus_rf.write_data;
  assign bus_wf.write_lanes   = bus_rf.write_lanes;
  assign bus_wf.read          = bus_rf.read;
  assign bus_wf.read_address  = bus_rf.read_address;

  dual_port_ram #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .BYTE_BITS(8), .READ_MODE(0)) dut_rf (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_rf.slave)
  );

  dual_port_ram #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .BYTE_BITS(8), .READ_MODE(1)) dut_wf (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_wf.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_rf [$];
  logic [31:0] exp_wf [$];

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] l);
    logic [31:0] m;
    m = o;
    for (int k = 0; k < 4; k++) if (l[k]) m[k*8 +: 8] = n[k*8 +: 8];
    return m;
  endfunction

  // Scoreboard: every read_valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus_rf.read_valid) begin
      checks++;
      if (exp_rf.size() == 0) begin
        errors++;
        $display("FAIL rf_unexpected_valid: got read_valid=1 data=%h, required no valid", bus_rf.read_data);
      end else begin
        logic [31:0] e;
        e = exp_rf.pop_front();
        if (bus_rf.read_data !== e) begin
          errors++;
          $display("FAIL rf_read_data: got %h required %h", bus_rf.read_data, e);
        end
      end
    end
    if (bus_wf.read_valid) begin
      checks++;
      if (exp_wf.size() == 0) begin
        errors++;
        $display("FAIL wf_unexpected_valid: got read_valid=1 data=%h, required no valid", bus_wf.read_data);
      end else begin
        logic [31:0] e;
        e = exp_wf.pop_front();
        if (bus_wf.read_data !== e) begin
          errors++;
          $display("FAIL wf_read_data: got %h required %h", bus_wf.read_data, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus_rf.clear         = 1'b0;
    bus_rf.write         = 1'b0;
    bus_rf.write_address = '0;
    bus_rf.write_data    = '0;
    bus_rf.write_lanes   = '0;
    bus_rf.read          = 1'b0;
    bus_rf.read_address  = '0;
  endtask

  // One edge of stimulus; called just after a falling edge, returns after the next one.
  task automatic cycle(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] wl, input logic rd, input logic [3:0] ra,
                       input logic clr, input logic accepted);
    bus_rf.clear         = clr;
    bus_rf.write         = wr;
    bus_rf.write_address = wa;
    bus_rf.write_data    = wd;
    bus_rf.write_lanes   = wl;
    bus_rf.read          = rd;
    bus_rf.read_address  = ra;
    if (accepted && clr) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (accepted) begin
      if (rd) begin
        exp_rf.push_back(model[ra]);
        exp_wf.push_back((wr && wa == ra) ? tb_merge(model[ra], wd, wl) : model[ra]);
      end
      if (wr) model[wa] = tb_merge(model[wa], wd, wl);
    end
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] l);
    cycle(1'b1, a, d, l, 1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b0, 1'b1);
  endtask

  task automatic count_busy(input int expected, input string name);
    int n;
    n = 0;
    while (bus_rf.busy && n < 100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end
    checks++;
    if (n !== expected || bus_wf.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_edges: got %0d (wf busy=%b) required %0d (wf busy=0)",
               name, n, bus_wf.busy, expected);
    end
  endtask

  task automatic drain(input string name);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_rf.size() != 0 || exp_wf.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: got %0d/%0d reads outstanding, required 0/0",
               name, exp_rf.size(), exp_wf.size());
    end
    exp_rf.delete();
    exp_wf.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus_rf.busy !== 1'b1 || bus_rf.read_valid !== 1'b0 || bus_rf.read_data !== 32'd0 ||
        bus_wf.busy !== 1'b1 || bus_wf.read_valid !== 1'b0 || bus_wf.read_data !== 32'd0) begin
      errors++;
      $display("FAIL %s_reset_outputs: got busy=%b/%b valid=%b/%b data=%h/%h required 1/1 0/0 0/0",
               name, bus_rf.busy, bus_wf.busy, bus_rf.read_valid, bus_wf.read_valid,
               bus_rf.read_data, bus_wf.read_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    count_busy(16, "reset");
    for (int a = 0; a < DEPTH; a++) rd(4'(a));
    drain("reset");
  endtask

  task automatic test_byte_lanes();
    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    checks++;
    if (bus_rf.read_valid !== 1'b1 || bus_rf.read_data !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL lanes_read: got valid=%b data=%h required valid=1 data=aa22cc44",
               bus_rf.read_valid, bus_rf.read_data);
    end
    @(negedge clock);
    checks++;
    if (bus_rf.read_valid !== 1'b0 || bus_wf.read_valid !== 1'b0) begin
      errors++;
      $display("FAIL lanes_valid_width: got valid=%b/%b one cycle later, required 0/0",
               bus_rf.read_valid, bus_wf.read_valid);
    end
    wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    rd(4'd3);
    drain("lanes");
  endtask

  task automatic test_collision();
    wr(4'd5, 32'h12345678, 4'b1111);
    cycle(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'd5, 1'b0, 1'b1);
    checks++;
    if (bus_rf.read_data !== 32'h12345678 || bus_wf.read_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL collision_same_edge: got rf=%h wf=%h required rf=12345678 wf=ffffffff",
               bus_rf.read_data, bus_wf.read_data);
    end
    rd(4'd5);
    checks++;
    if (bus_rf.read_data !== 32'hFFFFFFFF || bus_wf.read_data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL collision_next_edge: got rf=%h wf=%h required ffffffff both",
               bus_rf.read_data, bus_wf.read_data);
    end
    cycle(1'b1, 4'd5, 32'h00000000, 4'b0011, 1'b1, 4'd5, 1'b0, 1'b1);
    cycle(1'b1, 4'd7, 32'hCAFEF00D, 4'b1111, 1'b1, 4'd5, 1'b0, 1'b1);
    rd(4'd7);
    rd(4'd5);
    drain("collision");
  endtask

  task automatic test_clear_active();
    wr(4'd2, 32'h00000099, 4'b1111);
    cycle(1'b1, 4'd2, 32'd7, 4'b1111, 1'b1, 4'd2, 1'b1, 1'b1);
    checks++;
    if (bus_rf.busy !== 1'b1 || bus_rf.read_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_accept: got busy=%b valid=%b required busy=1 valid=0",
               bus_rf.busy, bus_rf.read_valid);
    end
    count_busy(16, "clear");
    rd(4'd2);
    checks++;
    if (bus_rf.read_data !== 32'd0 || bus_wf.read_data !== 32'd0) begin
      errors++;
      $display("FAIL clear_addr2: got %h/%h required 0/0", bus_rf.read_data, bus_wf.read_data);
    end
    drain("clear");
  endtask

  task automatic test_busy_requests();
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 4'd6, 32'h00000055, 4'b1111, 1'b1, 4'd6, 1'b0, 1'b0);
    count_busy(13, "busy_req");
    rd(4'd6);
    drain("busy_req");
  endtask

  task automatic test_reset_mid_sweep();
    wr(4'd12, 32'hDEADBEEF, 4'b1111);
    rd(4'd12);
    cycle(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
    repeat (9) @(negedge clock);
    checks++;
    if (bus_rf.busy !== 1'b1 || bus_rf.read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL midsweep_hold: got busy=%b data=%h required busy=1 data=deadbeef",
               bus_rf.busy, bus_rf.read_data);
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midsweep");
    @(negedge clock);
    reset_n = 1'b1;
    count_busy(16, "midsweep");
    rd(4'd12);
    drain("midsweep");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_byte_lanes();
    test_collision();
    test_clear_active();
    test_busy_requests();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
